// File: rtl/hft_stock_scheduler_pkg.sv
// rtl/hft_stock_scheduler_pkg.sv - shared types and constants for the stock scheduler
package hft_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  // Width of a stock index; never narrower than one bit.
  function automatic int stock_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hft_stock_scheduler_if.sv
// rtl/hft_stock_scheduler_if.sv - request/issue/completion bundle between front end, scheduler and datapath
interface hft_stock_scheduler_if #(
  parameter int NUM_STOCKS = 4,
  parameter int CNT_WIDTH  = 32
);
  localparam int ID_W = hft_sched_pkg::stock_id_w(NUM_STOCKS);

  logic [NUM_STOCKS-1:0] i_req;
  logic                  i_book_is_busy;
  logic                  i_dp_valid;
  logic                  i_clear_err;
  logic                  o_issue_valid;
  logic [ID_W-1:0]       o_issue_stock_id;
  logic                  o_done;
  logic [ID_W-1:0]       o_done_stock_id;
  logic [NUM_STOCKS-1:0] o_pending;
  logic                  o_busy;
  logic                  o_timeout;
  logic [ID_W-1:0]       o_err_stock_id;
  logic [CNT_WIDTH-1:0]  o_issue_count;

  modport slave (
    input  i_req, i_book_is_busy, i_dp_valid, i_clear_err,
    output o_issue_valid, o_issue_stock_id, o_done, o_done_stock_id,
           o_pending, o_busy, o_timeout, o_err_stock_id, o_issue_count
  );

  modport master (
    output i_req, i_book_is_busy, i_dp_valid, i_clear_err,
    input  o_issue_valid, o_issue_stock_id, o_done, o_done_stock_id,
           o_pending, o_busy, o_timeout, o_err_stock_id, o_issue_count
  );

endinterface

// File: rtl/hft_stock_scheduler_rr_arbiter.sv
// rtl/hft_stock_scheduler_rr_arbiter.sv - combinational round-robin pick with optional stock-0 override
module hft_rr_arbiter #(
  parameter int NUM_STOCKS = 4,
  parameter int ID_W       = 2
) (
  input  logic [NUM_STOCKS-1:0] i_pending,
  input  logic [ID_W-1:0]       i_ptr,
  input  logic                  i_prio_en,
  output logic [NUM_STOCKS-1:0] o_grant,
  output logic [ID_W-1:0]       o_index,
  output logic                  o_any
);

  logic [ID_W-1:0] w_idx;
  logic            w_found;

  always_comb begin
    o_grant = '0;
    o_index = '0;
    o_any   = |i_pending;
    w_idx   = '0;
    w_found = 1'b0;
    // Scan from the pointer upward, wrapping, and keep the first hit.
    for (int i = 0; i < NUM_STOCKS; i++) begin
      w_idx = ID_W'((int'(i_ptr) + i) % NUM_STOCKS);
      if (!w_found && i_pending[w_idx]) begin
        w_found = 1'b1;
        o_index = w_idx;
      end
    end
    if (i_prio_en && i_pending[0]) begin
      o_index = '0;
    end
    if (o_any) begin
      o_grant[o_index] = 1'b1;
    end
  end

endmodule

// File: rtl/hft_stock_scheduler.sv
// rtl/hft_stock_scheduler.sv - issues one pending stock at a time to the shared datapath with a timeout watchdog
// Optional build macro: HFT_SCHED_PRIORITY_EN (stock 0 strict priority).
module hft_stock_scheduler
  import hft_sched_pkg::*;
#(
  parameter int NUM_STOCKS     = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  hft_stock_scheduler_if.slave  bus
);

  localparam int                ID_W     = stock_id_w(NUM_STOCKS);
  localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(NUM_STOCKS - 1);

  sched_state_t          r_state;
  sched_state_t          w_state_nxt;
  logic [NUM_STOCKS-1:0] r_pending;
  logic [NUM_STOCKS-1:0] r_win_grant;
  logic [ID_W-1:0]       r_ptr;
  logic [TMR_W-1:0]      r_timer;
  logic [ID_W-1:0]       r_issue_id;
  logic                  r_done;
  logic [ID_W-1:0]       r_done_id;
  logic                  r_timeout;
  logic [ID_W-1:0]       r_err_id;
  logic [CNT_WIDTH-1:0]  r_issue_count;

  logic [NUM_STOCKS-1:0] w_arb_grant;
  logic [ID_W-1:0]       w_arb_index;
  logic                  w_arb_any;
  logic                  w_prio_en;
  logic                  w_launch;
  logic                  w_done_evt;
  logic                  w_to_evt;
  logic [NUM_STOCKS-1:0] w_clr;
  logic [ID_W-1:0]       w_ptr_nxt;

`ifdef HFT_SCHED_PRIORITY_EN
  assign w_prio_en = 1'b1;
`else
  assign w_prio_en = 1'b0;
`endif

  hft_rr_arbiter #(
    .NUM_STOCKS (NUM_STOCKS),
    .ID_W       (ID_W)
  ) u_arb (
    .i_pending (r_pending),
    .i_ptr     (r_ptr),
    .i_prio_en (w_prio_en),
    .o_grant   (w_arb_grant),
    .o_index   (w_arb_index),
    .o_any     (w_arb_any)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_done_evt  = 1'b0;
    w_to_evt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_any && !bus.i_book_is_busy) begin
          w_state_nxt = ISSUE;
          w_launch    = 1'b1;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        // A result on the last counted cycle still counts as success.
        if (bus.i_dp_valid) begin
          w_done_evt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_timer == TMR_LAST) begin
          w_to_evt    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_clr     = (r_state == ISSUE) ? r_win_grant : '0;
    w_ptr_nxt = (r_issue_id == ID_LAST) ? '0 : r_issue_id + ID_W'(1);
    if (w_prio_en && (r_issue_id == '0)) begin
      w_ptr_nxt = r_ptr;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pending     <= '0;
      r_win_grant   <= '0;
      r_ptr         <= '0;
      r_timer       <= '0;
      r_issue_id    <= '0;
      r_done        <= 1'b0;
      r_done_id     <= '0;
      r_timeout     <= 1'b0;
      r_err_id      <= '0;
      r_issue_count <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | bus.i_req;
      r_done    <= w_done_evt;
      if (w_launch) begin
        r_issue_id  <= w_arb_index;
        r_win_grant <= w_arb_grant;
      end
      if (r_state == ISSUE) begin
        r_issue_count <= r_issue_count + CNT_WIDTH'(1);
      end
      if ((r_state == WAIT) && (w_state_nxt == WAIT)) begin
        r_timer <= r_timer + TMR_W'(1);
      end else begin
        r_timer <= '0;
      end
      if (w_done_evt) begin
        r_done_id <= r_issue_id;
        r_ptr     <= w_ptr_nxt;
      end
      if (w_to_evt) begin
        r_timeout <= 1'b1;
        r_err_id  <= r_issue_id;
        r_ptr     <= w_ptr_nxt;
      end else if (bus.i_clear_err) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign bus.o_issue_valid    = (r_state == ISSUE);
  assign bus.o_issue_stock_id = r_issue_id;
  assign bus.o_done           = r_done;
  assign bus.o_done_stock_id  = r_done_id;
  assign bus.o_pending        = r_pending;
  assign bus.o_busy           = (r_state != IDLE);
  assign bus.o_timeout        = r_timeout;
  assign bus.o_err_stock_id   = r_err_id;
  assign bus.o_issue_count    = r_issue_count;

endmodule

// File: tb/tb_hft_stock_scheduler.sv
// tb/tb_hft_stock_scheduler.sv - self-checking bench for hft_stock_scheduler (default build)
module tb_hft_stock_scheduler;

  localparam int N  = 4;
  localparam int TO = 64;
  localparam int CW = 32;

  typedef struct packed {
    logic [3:0]      req;
    logic [2:0]      n;
    logic [3:0][1:0] order;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hft_stock_scheduler_if #(.NUM_STOCKS(N), .CNT_WIDTH(CW)) bus ();

  hft_stock_scheduler #(
    .NUM_STOCKS     (N),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (CW)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [1:0] iss_q[$];
  logic [1:0] done_q[$];
  logic [1:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard: every issue and completion must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_issue_valid) begin
        if (iss_q.size() == 0) check("spurious_issue", 64'(bus.o_issue_valid), 64'd0);
        else begin
          mon_exp = iss_q.pop_front();
          check("issue_id", 64'(bus.o_issue_stock_id), 64'(mon_exp));
        end
      end
      if (bus.o_done) begin
        if (done_q.size() == 0) check("spurious_done", 64'(bus.o_done), 64'd0);
        else begin
          mon_exp = done_q.pop_front();
          check("done_id", 64'(bus.o_done_stock_id), 64'(mon_exp));
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_issue_valid"}, 64'(bus.o_issue_valid), 64'd0);
    check({tag, "_issue_id"},    64'(bus.o_issue_stock_id), 64'd0);
    check({tag, "_done"},        64'(bus.o_done), 64'd0);
    check({tag, "_done_id"},     64'(bus.o_done_stock_id), 64'd0);
    check({tag, "_pending"},     64'(bus.o_pending), 64'd0);
    check({tag, "_busy"},        64'(bus.o_busy), 64'd0);
    check({tag, "_timeout"},     64'(bus.o_timeout), 64'd0);
    check({tag, "_err_id"},      64'(bus.o_err_stock_id), 64'd0);
    check({tag, "_count"},       64'(bus.o_issue_count), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_req = '0;
    bus.i_book_is_busy = 1'b0;
    bus.i_dp_valid = 1'b0;
    bus.i_clear_err = 1'b0;
    iss_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_issue(output int c);
    c = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.o_issue_valid) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check("issue_within_bound", 64'(bus.o_issue_valid), 64'd1);
  endtask

  // Called at the negedge of the issue cycle; returns at the negedge of the done cycle.
  task automatic finish(input int lat);
    repeat (lat) @(negedge clk);
    bus.i_dp_valid = 1'b1;
    @(negedge clk);
    bus.i_dp_valid = 1'b0;
    check("done_latency", 64'(bus.o_done), 64'd1);
  endtask

  task automatic serve(input int lat);
    int ci;
    wait_issue(ci);
    finish(lat);
  endtask

  vec_t vecs[6];
  int   c0, ci, seen;

  initial begin
    vecs[0] = '{req: 4'b1111, n: 3'd4, order: {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[1] = '{req: 4'b0100, n: 3'd1, order: {2'd0, 2'd0, 2'd0, 2'd2}};
    vecs[2] = '{req: 4'b0011, n: 3'd2, order: {2'd0, 2'd0, 2'd1, 2'd0}};
    vecs[3] = '{req: 4'b1001, n: 3'd2, order: {2'd0, 2'd0, 2'd0, 2'd3}};
    vecs[4] = '{req: 4'b0110, n: 3'd2, order: {2'd0, 2'd0, 2'd2, 2'd1}};
    vecs[5] = '{req: 4'b1101, n: 3'd3, order: {2'd0, 2'd2, 2'd0, 2'd3}};

    do_reset();
    check_zero("reset");

    // Single request: issue two cycles after the request, done one cycle after dp_valid.
    @(negedge clk);
    c0 = cyc;
    bus.i_req = 4'b0100;
    iss_q.push_back(2'd2);
    done_q.push_back(2'd2);
    @(negedge clk);
    bus.i_req = '0;
    wait_issue(ci);
    check("issue_latency", 64'(ci), 64'(c0 + 2));
    check("busy_in_issue", 64'(bus.o_busy), 64'd1);
    finish(5);
    check("single_count", 64'(bus.o_issue_count), 64'd1);
    check("single_busy_after", 64'(bus.o_busy), 64'd0);

    // Round-robin order table, pointer carried across vectors from reset.
    do_reset();
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      bus.i_req = vecs[v].req;
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        iss_q.push_back(vecs[v].order[k]);
        done_q.push_back(vecs[v].order[k]);
      end
      @(negedge clk);
      bus.i_req = '0;
      for (int k = 0; k < int'(vecs[v].n); k++) serve(3);
      check("vec_pending_drained", 64'(bus.o_pending), 64'd0);
      check("vec_issue_q_empty", 64'(iss_q.size()), 64'd0);
    end
    check("table_count", 64'(bus.o_issue_count), 64'd14);

    // Busy gating.
    bus.i_book_is_busy = 1'b1;
    @(negedge clk);
    bus.i_req = 4'b0010;
    iss_q.push_back(2'd1);
    done_q.push_back(2'd1);
    @(negedge clk);
    bus.i_req = '0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.o_issue_valid) seen++;
    end
    check("busy_blocks_issue", 64'(seen), 64'd0);
    check("busy_pending_held", 64'(bus.o_pending), 64'b0010);
    c0 = cyc;
    bus.i_book_is_busy = 1'b0;
    wait_issue(ci);
    check("busy_release_latency", 64'(ci), 64'(c0 + 1));
    finish(3);

    // Timeout on stock 3, then clear.
    @(negedge clk);
    bus.i_req = 4'b1000;
    iss_q.push_back(2'd3);
    @(negedge clk);
    bus.i_req = '0;
    wait_issue(ci);
    repeat (TO) @(negedge clk);
    check("to_not_yet", 64'(bus.o_timeout), 64'd0);
    check("to_still_busy", 64'(bus.o_busy), 64'd1);
    @(negedge clk);
    check("to_flag", 64'(bus.o_timeout), 64'd1);
    check("to_err_id", 64'(bus.o_err_stock_id), 64'd3);
    check("to_idle", 64'(bus.o_busy), 64'd0);
    check("to_no_done", 64'(bus.o_done), 64'd0);
    bus.i_clear_err = 1'b1;
    @(negedge clk);
    bus.i_clear_err = 1'b0;
    check("to_cleared", 64'(bus.o_timeout), 64'd0);

    // dp_valid on the last counted WAIT cycle is a success.
    @(negedge clk);
    bus.i_req = 4'b0001;
    iss_q.push_back(2'd0);
    done_q.push_back(2'd0);
    @(negedge clk);
    bus.i_req = '0;
    wait_issue(ci);
    finish(TO);
    check("edge_no_timeout", 64'(bus.o_timeout), 64'd0);

    // Set wins over clear in the ISSUE cycle; stock 1 is reissued.
    @(negedge clk);
    bus.i_req = 4'b0010;
    iss_q.push_back(2'd1);
    iss_q.push_back(2'd1);
    done_q.push_back(2'd1);
    done_q.push_back(2'd1);
    @(negedge clk);
    bus.i_req = '0;
    wait_issue(ci);
    bus.i_req = 4'b0010;
    @(negedge clk);
    bus.i_req = '0;
    check("coalesce_pending", 64'(bus.o_pending), 64'b0010);
    finish(2);
    serve(3);
    check("coalesce_drained", 64'(bus.o_pending), 64'd0);

    // Reset in the middle of WAIT.
    @(negedge clk);
    bus.i_req = 4'b0100;
    iss_q.push_back(2'd2);
    @(negedge clk);
    bus.i_req = '0;
    wait_issue(ci);
    @(negedge clk);
    check("mid_wait_busy", 64'(bus.o_busy), 64'd1);
    #2 rst = 1'b1;
    #1 check_zero("async_reset");
    iss_q.delete();
    done_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.i_dp_valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.o_done) seen++;
    end
    bus.i_dp_valid = 1'b0;
    check("late_dp_no_done", 64'(seen), 64'd0);
    check("late_dp_idle", 64'(bus.o_busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit (%0d/%0d)", n_pass, n_checks);
    $fatal(1);
  end

endmodule
